// File: rtl/bram_sum_reader.sv
// Reads a run of consecutive BRAM words (1-cycle read latency) and reports
// their unsigned sum with a one-cycle done pulse.
module bram_sum_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int SUM_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_vld_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    len_clamped;
  logic [SUM_W-1:0]    rd_word;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  // Bus contents are masked off unless a read was actually issued last cycle.
  assign rd_word     = rd_vld_q ? SUM_W'(rd_data) : '0;

  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    acc_d     = acc_q + rd_word;
    sum_d     = sum_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (len_clamped != '0) begin
            rem_d     = len_clamped - 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = base_addr;
            busy_d    = 1'b1;
            state_d   = READ;
          end else begin
            // Empty job passes through DRAIN so done still lands one edge later.
            state_d = DRAIN;
          end
        end
      end
      READ: begin
        if (rem_q == '0) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
        end
      end
      DRAIN: begin
        sum_d   = acc_q + rd_word;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_vld_q  <= rd_en_q;
      rd_addr_q <= rd_addr_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;

endmodule
